// File: rtl/huc3_rtc_sched.sv
// HuC3 RTC scheduler: 1 s tick divider, running host timestamp, and the
// increment/load strobes that replay elapsed seconds after a save restore.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | only real-time ticks are forwarded to the counter
// ST_LOAD    | one cycle: counter loads the saved image, backlog is computed
// ST_CATCHUP | one increment per cycle until the backlog drains
module huc3_rtc_sched #(
  parameter int unsigned TICK_CYCLES = 33554432,
  parameter logic [31:0] MAX_BACKLOG = 32'hFFFF_FFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] host_ts,
  input  logic        host_ts_tgl,
  input  logic [31:0] save_ts,
  input  logic        save_valid,
  input  logic        cpu_set,
  output logic        inc_out,
  output logic        load_out,
  output logic        busy,
  output logic [31:0] ts_out,
  output logic [31:0] backlog,
  output logic        sat_flag
);

  localparam int unsigned SUB_W = $clog2(TICK_CYCLES);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CATCHUP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SUB_W-1:0] sub;
  logic             sec_tick;
  logic             tgl_q;
  logic [31:0]      save_q;
  logic [31:0]      save_d;
  logic [31:0]      backlog_d;
  logic             sat_d;
  logic [31:0]      diff;

  assign sec_tick = (sub == SUB_LAST);

  // Divider free-runs so the RTC keeps time even while the mapper is idle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sub <= '0;
    end else if (cpu_set || sec_tick) begin
      sub <= '0;
    end else begin
      sub <= sub + 1'b1;
    end
  end

  // A fresh host timestamp wins over the local one-second increment.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tgl_q  <= 1'b0;
      ts_out <= '0;
    end else begin
      tgl_q <= host_ts_tgl;
      if (host_ts_tgl != tgl_q) begin
        ts_out <= host_ts;
      end else if (sec_tick) begin
        ts_out <= ts_out + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      save_q   <= '0;
      backlog  <= '0;
      sat_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      save_q   <= save_d;
      backlog  <= backlog_d;
      sat_flag <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    save_d    = save_q;
    backlog_d = backlog;
    sat_d     = sat_flag;
    diff      = (ts_out > save_q) ? (ts_out - save_q) : 32'd0;

    if (!enable) begin
      state_d   = ST_IDLE;
      backlog_d = '0;
    end else if (save_valid) begin
      state_d = ST_LOAD;
      save_d  = save_ts;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_LOAD: begin
          backlog_d = (diff > MAX_BACKLOG) ? MAX_BACKLOG : diff;
          sat_d     = (diff > MAX_BACKLOG);
          state_d   = (backlog_d != 32'd0) ? ST_CATCHUP : ST_IDLE;
        end
        ST_CATCHUP: begin
          // On a real tick the single increment belongs to the live second.
          if (cpu_set) begin
            backlog_d = '0;
            state_d   = ST_IDLE;
          end else if (!sec_tick) begin
            backlog_d = backlog - 32'd1;
            if (backlog == 32'd1) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q == ST_CATCHUP);
  assign load_out = enable & (state_q == ST_LOAD);
  assign inc_out  = enable & (sec_tick | (busy & ~cpu_set));

endmodule

// File: tb/tb_huc3_rtc_sched.sv
// Bench for huc3_rtc_sched: two instances (full and tiny backlog limit) share
// stimulus; expectations come from a second-count model of the RTC.
module tb_huc3_rtc_sched;

  localparam int TICK = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] host_ts = '0;
  logic        host_ts_tgl = 1'b0;
  logic [31:0] save_ts = '0;
  logic        save_valid = 1'b0;
  logic        cpu_set = 1'b0;

  logic [1:0]  inc_o;
  logic [1:0]  load_o;
  logic [1:0]  busy_o;
  logic [1:0]  sat_o;
  logic [31:0] ts_o [2];
  logic [31:0] bl_o [2];

  int          m_phase;
  logic [31:0] m_ts;
  logic        m_tgl_q;
  int          ticks_cnt;
  int          inc_cnt [2];
  int          load_cnt [2];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  huc3_rtc_sched #(.TICK_CYCLES(TICK)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
    .host_ts(host_ts), .host_ts_tgl(host_ts_tgl),
    .save_ts(save_ts), .save_valid(save_valid), .cpu_set(cpu_set),
    .inc_out(inc_o[0]), .load_out(load_o[0]), .busy(busy_o[0]),
    .ts_out(ts_o[0]), .backlog(bl_o[0]), .sat_flag(sat_o[0])
  );

  huc3_rtc_sched #(.TICK_CYCLES(TICK), .MAX_BACKLOG(32'd5)) dut_sat (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
    .host_ts(host_ts), .host_ts_tgl(host_ts_tgl),
    .save_ts(save_ts), .save_valid(save_valid), .cpu_set(cpu_set),
    .inc_out(inc_o[1]), .load_out(load_o[1]), .busy(busy_o[1]),
    .ts_out(ts_o[1]), .backlog(bl_o[1]), .sat_flag(sat_o[1])
  );

  function automatic logic [31:0] maxb(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'd5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then advance the model across the posedge.
  task automatic step();
    @(negedge clk_sys);
    for (int k = 0; k < 2; k++) begin
      inc_cnt[k]  += int'(inc_o[k]);
      load_cnt[k] += int'(load_o[k]);
    end
    if (enable && m_phase == TICK - 1) ticks_cnt++;
    @(posedge clk_sys);
    if (host_ts_tgl != m_tgl_q) m_ts = host_ts;
    else if (m_phase == TICK - 1) m_ts = m_ts + 32'd1;
    m_tgl_q = host_ts_tgl;
    m_phase = (cpu_set || m_phase == TICK - 1) ? 0 : m_phase + 1;
    #1;
  endtask

  task automatic wait_phase(input int p);
    while (m_phase != p) step();
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ts    = '0;
    m_tgl_q = 1'b0;
  endtask

  task automatic set_host(input logic [31:0] v);
    host_ts     = v;
    host_ts_tgl = ~host_ts_tgl;
    step();
    chk("host_ts_load", ts_o[0], v);
  endtask

  // Restore from save_val and let both instances drain their backlog.
  task automatic burst(input logic [31:0] save_val);
    logic [31:0] diff;
    logic [31:0] eb [2];
    int guard;
    ticks_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      inc_cnt[k]  = 0;
      load_cnt[k] = 0;
    end
    save_ts    = save_val;
    save_valid = 1'b1;
    step();
    save_valid = 1'b0;
    diff = (m_ts > save_val) ? m_ts - save_val : 32'd0;
    for (int k = 0; k < 2; k++) begin
      eb[k] = (diff > maxb(k)) ? maxb(k) : diff;
      chk("load_pulse", load_o[k], 1'b1);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      chk("backlog_init", bl_o[k], eb[k]);
      chk("sat_flag", sat_o[k], diff > maxb(k));
      chk("busy_start", busy_o[k], eb[k] != 0);
    end
    guard = 0;
    while (busy_o != 2'b00 && guard < 2000) begin
      step();
      guard++;
    end
    chk("burst_timeout", guard < 2000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("inc_total", inc_cnt[k], ticks_cnt + int'(eb[k]));
      chk("load_count", load_cnt[k], 1);
      chk("backlog_end", bl_o[k], 0);
    end
    chk("ts_after_burst", ts_o[0], m_ts);
  endtask

  initial begin
    logic [31:0] hv;
    logic [31:0] sv;
    model_reset();
    ticks_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      inc_cnt[k]  = 0;
      load_cnt[k] = 0;
    end

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_inc", inc_o[k], 0);
      chk("rst_load", load_o[k], 0);
      chk("rst_busy", busy_o[k], 0);
      chk("rst_ts", ts_o[k], 0);
      chk("rst_backlog", bl_o[k], 0);
      chk("rst_sat", sat_o[k], 0);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    model_reset();

    // Free-running ticks: first inc at cycle 7, then every 8
    for (int i = 0; i < 24; i++) begin
      chk("tick_inc", inc_o[0], (i % TICK) == TICK - 1);
      chk("tick_inc_sat", inc_o[1], (i % TICK) == TICK - 1);
      chk("tick_load", load_o[0], 0);
      chk("tick_busy", busy_o[0], 0);
      chk("tick_ts", ts_o[0], m_ts);
      step();
    end
    chk("ts_after_3_ticks", ts_o[0], 3);

    // Catch-up of 10 seconds, restore in a non-tick cycle
    wait_phase(1);
    set_host(32'd1000);
    burst(32'd990);

    // Save newer than host: no catch-up
    burst(32'd2000);

    // Large backlog: saturated on the small-limit instance
    wait_phase(1);
    set_host(32'd1100);
    burst(32'd1000);

    // cpu_set during a 40-second catch-up
    wait_phase(1);
    set_host(32'd3040);
    save_ts    = 32'd3000;
    save_valid = 1'b1;
    step();
    save_valid = 1'b0;
    step();
    chk("cpu_backlog_init", bl_o[0], 40);
    repeat (10) step();
    while (m_phase == TICK - 1) step();
    cpu_set = 1'b1;
    #1;
    chk("cpu_cycle_inc", inc_o[0], 0);
    chk("cpu_cycle_busy", busy_o[0], 1);
    step();
    cpu_set = 1'b0;
    chk("cpu_busy_drop", busy_o[0], 0);
    chk("cpu_backlog", bl_o[0], 0);
    chk("cpu_sat_keep", sat_o[0], 0);
    for (int i = 1; i <= TICK; i++) begin
      chk("cpu_next_inc", inc_o[0], i == TICK);
      chk("cpu_next_inc_sat", inc_o[1], i == TICK);
      step();
    end

    // Randomized restores
    for (int r = 0; r < 6; r++) begin
      hv = 32'($urandom_range(1 << 30, 64));
      set_host(hv);
      repeat ($urandom_range(7, 0)) step();
      if (r % 3 == 2) sv = hv + 32'($urandom_range(10, 1));
      else sv = hv - 32'($urandom_range(30, 0));
      burst(sv);
    end

    // enable dropped mid catch-up
    wait_phase(1);
    set_host(32'd4050);
    save_ts    = 32'd4000;
    save_valid = 1'b1;
    step();
    save_valid = 1'b0;
    repeat (4) step();
    chk("en_busy_before", busy_o[0], 1);
    enable = 1'b0;
    #1;
    chk("en_inc_stop", inc_o[0], 0);
    step();
    chk("en_busy", busy_o[0], 0);
    chk("en_backlog", bl_o[0], 0);
    for (int i = 0; i < 20; i++) begin
      chk("dis_inc", inc_o[0], 0);
      chk("dis_load", load_o[0], 0);
      chk("dis_ts", ts_o[0], m_ts);
      save_valid = (i == 5);
      step();
    end
    save_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("reen_inc", inc_o[0], m_phase == TICK - 1);
      chk("reen_busy", busy_o[0], 0);
      step();
    end

    // reset_n pulsed mid catch-up
    wait_phase(1);
    set_host(32'd5050);
    save_ts    = 32'd5000;
    save_valid = 1'b1;
    step();
    save_valid = 1'b0;
    repeat (4) step();
    chk("rst_busy_before", busy_o[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_inc", inc_o[0], 0);
    chk("mid_rst_busy", busy_o[0], 0);
    chk("mid_rst_backlog", bl_o[0], 0);
    chk("mid_rst_ts", ts_o[0], 0);
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_inc", inc_o[0], m_phase == TICK - 1);
      chk("post_rst_busy", busy_o[0], 0);
      chk("post_rst_ts", ts_o[0], m_ts);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/huc3_rtc_sched.md
Name: huc3_rtc_sched

Overview:
- Scheduler for the HuC3 RTC counter datapath (seconds/minutes/days). Generates every increment and load strobe that datapath receives.
- Owns the 1 s tick divider and the running host timestamp.
- After a save-file restore, replays elapsed wall-clock seconds as a fast catch-up burst, arbitrated against real-time ticks and CPU time-set writes.

Parameters:
- TICK_CYCLES, 33554432, clk_sys cycles per RTC second; must be ≥2.
- MAX_BACKLOG, 32'hFFFFFFFF, saturation limit for catch-up seconds.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  mapper selected; low = scheduler idle
- host_ts  in  32  host Unix time, seconds
- host_ts_tgl  in  1  toggles when host_ts is new
- save_ts  in  32  timestamp read from save file
- save_valid  in  1  one-cycle pulse: save_ts and saved time image are valid
- cpu_set  in  1  one-cycle pulse: CPU wrote minute nibble 0 (time set)
- inc_out  out  1  one-cycle pulse: counter advances by one second
- load_out  out  1  one-cycle pulse: counter loads saved time image
- busy  out  1  catch-up in progress
- ts_out  out  32  running timestamp for save file
- backlog  out  32  remaining catch-up seconds
- sat_flag  out  1  last computed backlog was clamped

Behaviour:
- Reset (async, reset_n=0): all registers 0, including state, divider, ts_out, backlog, sat_flag and the toggle sampler. All outputs 0.
- Divider:
  - sub counts 0..TICK_CYCLES-1 and wraps; runs regardless of enable.
  - sec_tick = (sub == TICK_CYCLES-1).
  - cpu_set forces sub <= 0 and takes priority over the count.
- Timestamp:
  - sec_tick: ts_out <= ts_out+1, 32-bit wrap.
  - host_ts_tgl differs from its registered copy: ts_out <= host_ts. This overrides the same-cycle increment.
  - ts_out updates regardless of enable.
- FSM states: IDLE, LOAD, CATCHUP.
  - IDLE: save_valid -> LOAD. save_ts is captured.
  - LOAD (exactly one cycle): load_out=1. diff = (ts_out > saved) ? ts_out-saved : 0, compared unsigned. backlog <= min(diff, MAX_BACKLOG). sat_flag <= (diff > MAX_BACKLOG). Next state is CATCHUP if the result is >0, else IDLE.
  - CATCHUP: inc_out=1 every cycle.
    - backlog decrements by 1 except on sec_tick cycles, where the single inc serves the real second and backlog holds.
    - Reaching 0 -> IDLE. The last inc_out is the cycle backlog goes 1→0.
  - save_valid in any state -> LOAD, restarting with the new save_ts.
  - cpu_set in CATCHUP: backlog <= 0, state -> IDLE next edge, sat_flag unchanged. The cpu_set cycle itself is not inc'd unless sec_tick.
- inc_out = enable & (sec_tick | state==CATCHUP). At most one pulse per cycle; never two increments in one cycle.
- Outputs inc_out/load_out/busy are combinational from registered state and sub. busy = (state==CATCHUP).
- Latency: save_valid at edge N -> load_out high cycle N..N+1 -> first catch-up inc in the following cycle.
- enable=0:
  - Synchronously forces state IDLE and backlog 0.
  - inc_out/load_out held 0; save_valid ignored.
  - Divider and ts_out keep running.
  - Re-enable resumes in IDLE.
- Reset asserted mid-CATCHUP: immediate clear; no further inc_out after deassertion until a new save_valid.

Test Plan:
- TICK_CYCLES=8, reset release:
  - inc_out pulses every 8 cycles, first at cycle 7.
  - ts_out = 1 after the first tick.
  - load_out, busy = 0.
- host_ts=1000 with tgl toggled, then save_ts=990 + save_valid in a non-tick cycle:
  - one load_out cycle, then busy.
  - Catch-up is 10 catch-up incs plus 1 extra inc for each sec_tick during the burst. Total inc count in the window is verified.
  - backlog ends 0; busy drops.
- save_ts=2000 > ts_out=1000:
  - load_out pulse, backlog=0, no catch-up incs, state returns IDLE.
- MAX_BACKLOG=5, diff=100:
  - backlog=5, sat_flag=1, exactly 5 catch-up incs.
- cpu_set mid-CATCHUP (backlog=40):
  - busy deasserts next cycle, sub resets to 0.
  - Next real inc 8 cycles after cpu_set.
- enable dropped mid-CATCHUP, then reset_n pulsed low during a later burst:
  - inc_out stops immediately in both cases; backlog=0.
  - ts_out continues counting through enable=0 and reads 0 after reset.
